// File: rtl/mult_seq.sv
// mult_seq: iterative unsigned shift-and-add multiplier sequencer.
// Drives one 64-bit ripple-carry adder, one partial product per clock,
// and returns the low 64 bits of a*b on a one-cycle done pulse.
// Optional feature: define MULT_SEQ_EARLY_EXIT_EN to end the run as soon
// as the remaining multiplier bits are all zero.

module RcaAdder64 (
    input  logic [63:0] opA,
    input  logic [63:0] opB,
    output logic [63:0] sum
);
    // Carry into each bit position; the carry-out of bit 63 is never needed.
    logic [63:0] carry;

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 63; i++) begin : gCarry
            assign carry[i+1] = (opA[i] & opB[i]) | (opA[i] & carry[i]) | (opB[i] & carry[i]);
        end
    endgenerate

    assign sum = opA ^ opB ^ carry;
endmodule

module mult_seq #(
    parameter int BITS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [63:0] mcand_q;
    logic [63:0] mplier_q;
    logic [63:0] acc_q;
    logic [6:0]  count_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    logic [63:0] addB;
    logic [63:0] acc_d;
    logic [63:0] mcand_d;
    logic [63:0] mplier_d;
    logic [6:0]  count_d;
    logic        lastIter;

    // The multiplicand only enters the sum when the current multiplier bit is set.
    assign addB = mplier_q[0] ? mcand_q : 64'd0;

    RcaAdder64 uAdder (
        .opA (acc_q),
        .opB (addB),
        .sum (acc_d)
    );

    // Next values for one RUN iteration and the decision whether it is the last one.
    always_comb begin
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[63:1]};
        count_d  = count_q + 7'd1;
        lastIter = (count_d == 7'(BITS));
`ifdef MULT_SEQ_EARLY_EXIT_EN
        lastIter = lastIter | (mplier_d == 64'd0);
`else
        lastIter = lastIter | 1'b0;
`endif
    end

    // Sequencer FSM with the operand/accumulator registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= RUN;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_d;
                    if (lastIter) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vector table plus hand-written multi-cycle sequences
// for the mult_seq sequencer. Expected latencies follow MULT_SEQ_EARLY_EXIT_EN.

module tb_mult_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int testsRun  = 0;
    int failCount = 0;
    int doneCount = 0;
    int readyLowCount = 0;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expProd;
        int          latNoEe;
        int          latEe;
    } vec_t;

    vec_t vecs[11];

    mult_seq #(.BITS(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses and not-ready cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount = doneCount + 1;
        if (ready !== 1'b1) readyLowCount = readyLowCount + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun = testsRun + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference latency with early exit: one edge past the top set bit of b, or 1 when b is zero.
    function automatic int eeLatency(input logic [63:0] bv);
        int lat;
        lat = 1;
        for (int i = 0; i < 64; i++) begin
            if (bv[i]) lat = i + 1;
        end
        return lat;
    endfunction

    // Launch one operation, wait for done, and check product, latency and pulse width.
    task automatic applyStimulus(input logic [63:0] av, input logic [63:0] bv,
                                 input logic [63:0] expProd, input int expLat, input string name);
        int guard;
        int lat;
        int done0;
        bit seen;
        guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        done0 = doneCount;
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = ~bv;
        checkOutput({name, " busy after start"}, {63'd0, busy}, 64'd1);
        seen = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat = n;
                break;
            end
        end
        if (!seen) begin
            checkOutput({name, " done timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
            checkOutput({name, " product"}, product, expProd);
            @(posedge clk);
            #1;
            checkOutput({name, " done one cycle"}, {63'd0, done}, 64'd0);
            checkOutput({name, " ready back"}, {63'd0, ready}, 64'd1);
            checkOutput({name, " product held"}, product, expProd);
            checkOutput({name, " done pulses"}, 64'(doneCount - done0), 64'd1);
        end
    endtask

    initial begin
        int ignEdge;
        int rstEdge;
        int lat;
        int done0;
        int rlow0;
        bit seen;
        logic [63:0] ra;
        logic [63:0] rb;

        vecs[0]  = '{64'd3, 64'd5, 64'd15, 64, 3};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64, 2};
        vecs[2]  = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 64, 2};
        vecs[3]  = '{64'h1234, 64'd1, 64'h1234, 64, 1};
        vecs[4]  = '{64'd5, 64'd0, 64'd0, 64, 1};
        vecs[5]  = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64, 64};
        vecs[6]  = '{64'd6, 64'd7, 64'd42, 64, 3};
        vecs[7]  = '{64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 64, 33};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64, 64};
        vecs[9]  = '{64'h0123_4567_89AB_CDEF, 64'h10, 64'h1234_5678_9ABC_DEF0, 64, 5};
        vecs[10] = '{64'd12345, 64'd1000, 64'd12345000, 64, 10};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        checkOutput("reset ready", {63'd0, ready}, 64'd1);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expProd,
                          EARLY ? vecs[i].latEe : vecs[i].latNoEe, $sformatf("vec%0d", i));
        end

        // Starts while RUN and during DONE must be ignored.
        ignEdge = EARLY ? 2 : 10;
        @(negedge clk);
        done0 = doneCount;
        rlow0 = readyLowCount;
        start = 1'b1;
        a = 64'd6;
        b = 64'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = '0;
        b = '0;
        seen = 1'b0;
        lat = 0;
        for (int e = 1; e <= 200; e++) begin
            if (e == ignEdge) begin
                @(negedge clk);
                start = 1'b1;
                a = 64'd7;
                b = 64'd7;
            end
            @(posedge clk);
            #1;
            if (e == ignEdge) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat = e;
                break;
            end
        end
        if (!seen) begin
            checkOutput("ignore done timeout", 64'd0, 64'd1);
        end else begin
            start = 1'b1;
            a = 64'd7;
            b = 64'd7;
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput("ignore ready after done", {63'd0, ready}, 64'd1);
            checkOutput("ignore product", product, 64'd42);
            repeat (5) @(posedge clk);
            #1;
            checkOutput("ignore product stays", product, 64'd42);
            checkOutput("ignore done pulses", 64'(doneCount - done0), 64'd1);
            checkOutput("ignore not-ready cycles", 64'(readyLowCount - rlow0), 64'(lat + 1));
        end

        // Asynchronous reset in the middle of a run aborts it.
        rstEdge = EARLY ? 2 : 30;
        @(negedge clk);
        done0 = doneCount;
        start = 1'b1;
        a = 64'd9;
        b = 64'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (rstEdge) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort product", product, 64'd0);
        checkOutput("abort done", {63'd0, done}, 64'd0);
        checkOutput("abort ready", {63'd0, ready}, 64'd1);
        checkOutput("abort busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort no done", 64'(doneCount - done0), 64'd0);
        applyStimulus(64'd9, 64'd9, 64'd81, EARLY ? 4 : 64, "after abort");

        // Random operands with a varied multiplier width.
        for (int r = 0; r < 30; r++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            applyStimulus(ra, rb, ra * rb, EARLY ? eeLatency(rb) : 64, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
